// File: rtl/bus_arbiter_if.sv
// Core-side request/response buses and the shared memory port seen by bus_arbiter.
// The slave view belongs to the arbiter. The master view belongs to the environment
// (fetch unit, memory stage and memory port) that surrounds it.
interface bus_arbiter_if;
  // Instruction fetch port
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_ok;
  logic [31:0] iresp_data;

  // Data port
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_ok;
  logic [63:0] dresp_data;

  // Shared memory port
  logic        mreq_valid;
  logic [63:0] mreq_addr;
  logic [2:0]  mreq_size;
  logic [7:0]  mreq_strobe;
  logic [63:0] mreq_data;
  logic        mresp_ok;
  logic [63:0] mresp_data;

  // Debug view of the current bus owner
  logic [1:0]  owner;

  modport slave (
    input  ireq_valid, ireq_addr,
    output iresp_ok, iresp_data,
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_ok, dresp_data,
    output mreq_valid, mreq_addr, mreq_size, mreq_strobe, mreq_data,
    input  mresp_ok, mresp_data,
    output owner
  );

  modport master (
    output ireq_valid, ireq_addr,
    input  iresp_ok, iresp_data,
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_ok, dresp_data,
    input  mreq_valid, mreq_addr, mreq_size, mreq_strobe, mreq_data,
    output mresp_ok, mresp_data,
    input  owner
  );
endinterface

// File: rtl/bus_arbiter.sv
// Shares a single-beat memory port between instruction fetch (I) and the data bus (D).
// A winner is picked only while idle. Its request is latched and held on the memory
// port until mresp_ok arrives. The completion is then returned to that owner alone,
// and only if the owner is still requesting.
module bus_arbiter #(
  parameter int RR_MODE      = 0,
  parameter int STARVE_LIMIT = 4
) (
  input logic         clk,
  input logic         reset,
  bus_arbiter_if.slave bus
);

  localparam int         CNT_W  = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [2:0] MSIZE4 = 3'd2;

  // The state encoding doubles as the debug owner code.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [63:0] r_addr;
  logic [2:0]  r_size;
  logic [7:0]  r_strobe;
  logic [63:0] r_data;
  logic        r_abandon;
  logic        r_last_d;
  logic [CNT_W-1:0] r_starve_cnt;

  logic        w_grant_i;
  logic        w_grant_d;
  logic        w_starved;
  logic        w_owner_valid;
  logic        w_done;

  assign w_starved = (r_starve_cnt == CNT_W'(STARVE_LIMIT));

  // The requester that owns the bus must keep its valid asserted.
  // Otherwise the transaction is treated as abandoned.
  assign w_owner_valid = (r_state == BUSY_I) ? bus.ireq_valid :
                         (r_state == BUSY_D) ? bus.dreq_valid : 1'b0;

  // A delivered completion requires all of the following:
  //   - we are busy and not in reset;
  //   - the owner is still asking;
  //   - the owner never let go during this transaction.
  assign w_done = !reset && (r_state != IDLE) && bus.mresp_ok &&
                  w_owner_valid && !r_abandon;

  // Next state and arbitration; a grant is only ever made from IDLE
  always_comb begin
    w_next_state = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.ireq_valid && bus.dreq_valid) begin
          if (RR_MODE != 0) begin
            w_grant_i = r_last_d;
          end else begin
            w_grant_i = w_starved;
          end
          w_grant_d = !w_grant_i;
        end else begin
          w_grant_i = bus.ireq_valid;
          w_grant_d = bus.dreq_valid;
        end
        if (w_grant_i) begin
          w_next_state = BUSY_I;
        end else if (w_grant_d) begin
          w_next_state = BUSY_D;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.mresp_ok) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State register; any mresp_ok in flight during reset is dropped with the state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Latch the winner's request on the grant and track abandonment while busy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr    <= '0;
      r_size    <= '0;
      r_strobe  <= '0;
      r_data    <= '0;
      r_abandon <= 1'b0;
    end else if (w_grant_i) begin
      r_addr    <= bus.ireq_addr;
      r_size    <= MSIZE4;
      r_strobe  <= '0;
      r_data    <= '0;
      r_abandon <= 1'b0;
    end else if (w_grant_d) begin
      r_addr    <= bus.dreq_addr;
      r_size    <= bus.dreq_size;
      r_strobe  <= bus.dreq_strobe;
      r_data    <= bus.dreq_data;
      r_abandon <= 1'b0;
    end else if ((r_state != IDLE) && !w_owner_valid) begin
      r_abandon <= 1'b1;
    end
  end

  // Fairness history:
  //   - r_last_d records which port was granted last (used in round-robin mode).
  //   - r_starve_cnt counts D grants made while I was waiting (fixed mode only).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_d     <= 1'b0;
      r_starve_cnt <= '0;
    end else if (w_grant_i) begin
      r_last_d     <= 1'b0;
      r_starve_cnt <= '0;
    end else if (w_grant_d) begin
      r_last_d <= 1'b1;
      if ((RR_MODE == 0) && bus.ireq_valid && !w_starved) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
    end
  end

  // The memory-port request is the registered busy state plus the latched fields.
  assign bus.mreq_valid  = (r_state != IDLE);
  assign bus.mreq_addr   = r_addr;
  assign bus.mreq_size   = r_size;
  assign bus.mreq_strobe = r_strobe;
  assign bus.mreq_data   = r_data;
  assign bus.owner       = r_state;

  // Completion goes to the owner only.
  // Response data is zero whenever no pulse is being delivered.
  assign bus.iresp_ok   = w_done && (r_state == BUSY_I);
  assign bus.dresp_ok   = w_done && (r_state == BUSY_D);
  assign bus.iresp_data = !bus.iresp_ok ? 32'h0 :
                          (r_addr[2] ? bus.mresp_data[63:32] : bus.mresp_data[31:0]);
  assign bus.dresp_data = bus.dresp_ok ? bus.mresp_data : 64'h0;

endmodule
